// File: rtl/multiplier_pipelined.sv
// multiplier_pipelined
//    Pipelined WA x WB integer multiplier with valid/ready streams on both
//    sides. Each beat picks signed or unsigned arithmetic and carries a tag
//    through the pipe. The full WA+WB-bit product is always returned.
//
//    Pipeline: stage 1 holds the input operands, the product is formed
//    combinationally from stage 1, LATENCY-2 delay stages follow, and the
//    last stage holds the output registers. The whole pipe advances together
//    whenever the output is empty or being taken (adv). Bubbles are kept.
//
// Ports
//    clk        clock, rising edge
//    rst        synchronous active-high reset
//    in_valid   operand beat valid
//    in_ready   pipe can accept a beat this cycle (equals adv)
//    in_a       operand A, WA bits
//    in_b       operand B, WB bits
//    in_signed  1: both operands two's complement, 0: both unsigned
//    in_tag     sideband tag returned with the result
//    in_acc     (MULT_ACC_EN only) add the product to the last emitted result
//    out_valid  result valid
//    out_ready  downstream takes the result
//    out_p      product, WA+WB bits
//    out_tag    tag of this result
//
// Build option
//    MULT_ACC_EN  adds in_acc; accumulation happens in the output stage.

module multiplier_pipelined #(
   parameter int WA      = 8,
   parameter int WB      = 8,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WA-1:0]    in_a,
   input  logic [WB-1:0]    in_b,
   input  logic             in_signed,
   input  logic [TAG_W-1:0] in_tag,
`ifdef MULT_ACC_EN
   input  logic             in_acc,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WA+WB-1:0] out_p,
   output logic [TAG_W-1:0] out_tag
);

   localparam int W  = WA + WB;
   localparam int ND = LATENCY - 2;

   logic adv;
   logic acc_in;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

`ifdef MULT_ACC_EN
   assign acc_in = in_acc;
`else
   assign acc_in = 1'b0;
`endif

   // stage 1: operand registers
   logic             s1_valid;
   logic [WA-1:0]    s1_a;
   logic [WB-1:0]    s1_b;
   logic             s1_signed;
   logic [TAG_W-1:0] s1_tag;
   logic             s1_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_signed <= 1'b0;
         s1_tag    <= '0;
         s1_acc    <= 1'b0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s1_a      <= in_a;
         s1_b      <= in_b;
         s1_signed <= in_signed;
         s1_tag    <= in_tag;
         s1_acc    <= acc_in;
      end
   end

   // Extending both operands to W bits and keeping the low W bits of the
   // product gives the exact result for signed and unsigned alike.
   logic [W-1:0] ext_a;
   logic [W-1:0] ext_b;
   logic [W-1:0] prod_c;

   assign ext_a  = {{WB{s1_signed & s1_a[WA-1]}}, s1_a};
   assign ext_b  = {{WA{s1_signed & s1_b[WB-1]}}, s1_b};
   assign prod_c = ext_a * ext_b;

   // source for the output stage: either the product directly or the tail of
   // the delay chain
   logic             src_valid;
   logic [W-1:0]     src_p;
   logic [TAG_W-1:0] src_tag;
   logic             src_acc;

   generate
      if (ND > 0) begin : g_delay
         logic             d_valid [ND];
         logic [W-1:0]     d_p     [ND];
         logic [TAG_W-1:0] d_tag   [ND];
         logic             d_acc   [ND];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < ND; i++) begin
                  d_valid[i] <= 1'b0;
                  d_p[i]     <= '0;
                  d_tag[i]   <= '0;
                  d_acc[i]   <= 1'b0;
               end
            end else if (adv) begin
               d_valid[0] <= s1_valid;
               d_p[0]     <= prod_c;
               d_tag[0]   <= s1_tag;
               d_acc[0]   <= s1_acc;
               for (int i = 1; i < ND; i++) begin
                  d_valid[i] <= d_valid[i-1];
                  d_p[i]     <= d_p[i-1];
                  d_tag[i]   <= d_tag[i-1];
                  d_acc[i]   <= d_acc[i-1];
               end
            end
         end

         assign src_valid = d_valid[ND-1];
         assign src_p     = d_p[ND-1];
         assign src_tag   = d_tag[ND-1];
         assign src_acc   = d_acc[ND-1];
      end else begin : g_direct
         assign src_valid = s1_valid;
         assign src_p     = prod_c;
         assign src_tag   = s1_tag;
         assign src_acc   = s1_acc;
      end
   endgenerate

   // output stage and running value
   logic         xfer;
   logic [W-1:0] acc_run;
   logic [W-1:0] acc_base;

   assign xfer = out_valid && out_ready;
   // a result leaving on this very edge is the "last emitted" one for the
   // beat replacing it
   assign acc_base = xfer ? out_p : acc_run;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_p     <= '0;
         out_tag   <= '0;
         acc_run   <= '0;
      end else begin
         if (xfer) begin
            acc_run <= out_p;
         end
         if (adv) begin
            out_valid <= src_valid;
            out_p     <= src_acc ? (src_p + acc_base) : src_p;
            out_tag   <= src_tag;
         end
      end
   end

endmodule

// File: tb/tb_multiplier_pipelined.sv
module tb_multiplier_pipelined;

   typedef struct {
      logic [63:0] p;
      logic [3:0]  tag;
      logic        acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // default-parameter instance
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        in_signed = 1'b0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_p;
   logic [3:0]  out_tag;
`ifdef MULT_ACC_EN
   logic        in_acc = 1'b0;
`endif

   multiplier_pipelined u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .in_tag    (in_tag),
`ifdef MULT_ACC_EN
      .in_acc    (in_acc),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag)
   );

   // wide instance
   logic        w_rst = 1'b1;
   logic        w_in_valid = 1'b0;
   logic        w_in_ready;
   logic [15:0] w_in_a = '0;
   logic [11:0] w_in_b = '0;
   logic        w_in_signed = 1'b0;
   logic [3:0]  w_in_tag = '0;
   logic        w_out_valid;
   logic        w_out_ready = 1'b1;
   logic [27:0] w_out_p;
   logic [3:0]  w_out_tag;
`ifdef MULT_ACC_EN
   logic        w_in_acc = 1'b0;
`endif

   multiplier_pipelined #(.WA(16), .WB(12), .LATENCY(5), .TAG_W(4)) u_wide (
      .clk       (clk),
      .rst       (w_rst),
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready),
      .in_a      (w_in_a),
      .in_b      (w_in_b),
      .in_signed (w_in_signed),
      .in_tag    (w_in_tag),
`ifdef MULT_ACC_EN
      .in_acc    (w_in_acc),
`endif
      .out_valid (w_out_valid),
      .out_ready (w_out_ready),
      .out_p     (w_out_p),
      .out_tag   (w_out_tag)
   );

   exp_t q0[$];
   exp_t q1[$];
   logic [63:0] run0 = '0;

   function automatic logic [63:0] model(logic [63:0] a, logic [63:0] b,
                                         logic s, int wa, int wb);
      longint av, bv, p;
      logic [63:0] mask;
      av = longint'(a);
      bv = longint'(b);
      if (s && a[wa-1]) av = av - (longint'(1) << wa);
      if (s && b[wb-1]) bv = bv - (longint'(1) << wb);
      p = av * bv;
      mask = (64'd1 << (wa + wb)) - 64'd1;
      return 64'(p) & mask;
   endfunction

   task automatic check(string name, logic [63:0] obs, logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   // scoreboard for the default instance
   always @(negedge clk) begin
      exp_t e;
      logic [63:0] expv;
      if (rst) begin
         run0 = '0;
      end else begin
         if (out_valid && out_ready) begin
            if (q0.size() == 0) begin
               check("d0_unexpected_out", 64'(q0.size()), 64'd1);
            end else begin
               e = q0.pop_front();
               expv = e.acc ? ((run0 + e.p) & 64'hFFFF) : e.p;
               run0 = expv;
               check("d0_p", 64'(out_p), expv);
               check("d0_tag", 64'(out_tag), 64'(e.tag));
            end
         end
         if (in_valid && in_ready) begin
            e.p   = model(64'(in_a), 64'(in_b), in_signed, 8, 8);
            e.tag = in_tag;
`ifdef MULT_ACC_EN
            e.acc = in_acc;
`else
            e.acc = 1'b0;
`endif
            q0.push_back(e);
         end
      end
   end

   // scoreboard for the wide instance (accumulate never requested)
   always @(negedge clk) begin
      exp_t e;
      if (!w_rst) begin
         if (w_out_valid && w_out_ready) begin
            if (q1.size() == 0) begin
               check("w_unexpected_out", 64'(q1.size()), 64'd1);
            end else begin
               e = q1.pop_front();
               check("w_p", 64'(w_out_p), e.p);
               check("w_tag", 64'(w_out_tag), 64'(e.tag));
            end
         end
         if (w_in_valid && w_in_ready) begin
            e.p   = model(64'(w_in_a), 64'(w_in_b), w_in_signed, 16, 12);
            e.tag = w_in_tag;
            e.acc = 1'b0;
            q1.push_back(e);
         end
      end
   end

   initial begin
      logic        take;
      logic [15:0] held_p;
      logic [3:0]  held_tag;
      int          n;
      int          seen;

      // reset both instances
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      w_rst = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_p", 64'(out_p), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // unsigned max, latency of two edges
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_signed = 1'b0; in_tag = 4'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_early_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_due_valid", 64'(out_valid), 64'd1);
      check("uns_ff_ff", 64'(out_p), 64'hFE01);
      check("uns_tag", 64'(out_tag), 64'd3);

      // signed corner cases
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h80; in_signed = 1'b1; in_tag = 4'd5;
      @(posedge clk); #1;
      in_a = 8'h7F; in_b = 8'h80; in_tag = 4'd6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("sgn_m1_m128", 64'(out_p), 64'h0080);
      @(posedge clk); #1;
      check("sgn_127_m128", 64'(out_p), 64'hC080);

      // 20 back-to-back random beats
      for (int i = 0; i < 20; i++) begin
         in_valid  = 1'b1;
         in_a      = 8'($urandom_range(0, 255));
         in_b      = 8'($urandom_range(0, 255));
         in_signed = 1'($urandom_range(0, 1));
         in_tag    = 4'(i);
         #1;
         check("stream_in_ready", 64'(in_ready), 64'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 20 && q0.size() != 0; i++) @(posedge clk);
      #1;
      check("stream_drain", 64'(q0.size()), 64'd0);

      // backpressure: out_ready low for five cycles mid-stream
      in_valid  = 1'b1;
      in_a      = 8'($urandom_range(0, 255));
      in_b      = 8'($urandom_range(0, 255));
      in_signed = 1'($urandom_range(0, 1));
      in_tag    = 4'($urandom_range(0, 15));
      held_p    = '0;
      held_tag  = '0;
      for (int c = 0; c < 16; c++) begin
         out_ready = !(c >= 5 && c < 10);
         #1;
         if (!out_ready) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            if (c > 5) begin
               check("bp_hold_p", 64'(out_p), 64'(held_p));
               check("bp_hold_tag", 64'(out_tag), 64'(held_tag));
            end
            held_p   = out_p;
            held_tag = out_tag;
         end
         take = in_valid && in_ready;
         @(posedge clk); #1;
         if (take) begin
            in_a      = 8'($urandom_range(0, 255));
            in_b      = 8'($urandom_range(0, 255));
            in_signed = 1'($urandom_range(0, 1));
            in_tag    = 4'($urandom_range(0, 15));
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q0.size() != 0; i++) @(posedge clk);
      #1;
      check("bp_drain", 64'(q0.size()), 64'd0);

`ifdef MULT_ACC_EN
      // accumulate: 3*4 plain, then 5*6 added to it
      in_valid = 1'b1; in_a = 8'd3; in_b = 8'd4; in_signed = 1'b0; in_tag = 4'd1; in_acc = 1'b0;
      @(posedge clk); #1;
      in_a = 8'd5; in_b = 8'd6; in_tag = 4'd2; in_acc = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_acc = 1'b0;
      check("acc_first", 64'(out_p), 64'd12);
      @(posedge clk); #1;
      check("acc_second", 64'(out_p), 64'd42);
      repeat (2) @(posedge clk);
      #1;
`endif

      // wide instance: signed most-negative operands, five-edge latency
      w_in_valid = 1'b1; w_in_a = 16'h8000; w_in_b = 12'h800; w_in_signed = 1'b1; w_in_tag = 4'd9;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      n = 1;
      while (!w_out_valid && n <= 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("w_latency", 64'(n), 64'd5);
      check("w_sgn_corner", 64'(w_out_p), 64'h4000000);
      @(posedge clk); #1;

      // reset mid-operation: three beats in flight are discarded
      for (int i = 0; i < 3; i++) begin
         w_in_valid  = 1'b1;
         w_in_a      = 16'($urandom_range(0, 65535));
         w_in_b      = 12'($urandom_range(0, 4095));
         w_in_signed = 1'($urandom_range(0, 1));
         w_in_tag    = 4'(10 + i);
         @(posedge clk); #1;
      end
      w_in_valid = 1'b0;
      w_rst = 1'b1;
      @(posedge clk); #1;
      w_rst = 1'b0;
      q1.delete();
      check("w_rst_valid", 64'(w_out_valid), 64'd0);
      check("w_rst_p", 64'(w_out_p), 64'd0);
      seen = 0;
      for (int i = 0; i < 7; i++) begin
         if (w_out_valid) seen++;
         @(posedge clk); #1;
      end
      check("w_rst_no_ghosts", 64'(seen), 64'd0);

      w_in_valid = 1'b1; w_in_a = 16'd1234; w_in_b = 12'd567; w_in_signed = 1'b0; w_in_tag = 4'd7;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      n = 1;
      while (!w_out_valid && n <= 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("w_post_rst_latency", 64'(n), 64'd5);
      check("w_post_rst_p", 64'(w_out_p), 64'd699678);
      check("w_post_rst_tag", 64'(w_out_tag), 64'd7);
      repeat (2) @(posedge clk);
      #1;
      check("w_drain", 64'(q1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
